pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised inter-stage pipeline buffer for the MIPS pipeline. It is the successor to the fixed-field stage registers. It carries one opaque payload word between stages and adds:
- a valid/ready handshake, with an optional 2-entry skid buffer that fully registers backpressure;
- a synchronous flush that inserts a bubble;
- a saturating stall-cycle counter for performance monitoring.

The top level concatenates stage fields (instr, PC, writeReg, results) into `in_data`.

## Interface
Parameters:
- `W`, default 133: payload width in bits.
- `SKID`, default 1: 1 selects the 2-entry skid buffer with registered `in_ready`. 0 selects a single register with combinational `in_ready`.
- `CNT_W`, default 16: width of `stall_cnt`.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `flush`, input, 1: synchronous, active-high. Discards all held and incoming entries.
- `in_valid`, input, 1: upstream has a payload.
- `in_ready`, output, 1: buffer accepts a payload this cycle.
- `in_data`, input, W: upstream payload.
- `out_valid`, output, 1: `out_data` holds a valid payload.
- `out_ready`, input, 1: downstream accepts the payload this cycle.
- `out_data`, output, W: payload to the next stage. Equals 0 whenever `out_valid`=0.
- `stall_cnt`, output, CNT_W: number of cycles with `in_valid`=1 and `in_ready`=0. Saturates at all-ones.

## Operation
- An input transfer occurs when `in_valid` and `in_ready` are both 1. An output transfer occurs when `out_valid` and `out_ready` are both 1.
- Storage:
  - The main register (`main_v`, `main_d`) drives `out_valid`/`out_data` directly.
  - The skid register (`skid_v`, `skid_d`) exists only when SKID=1.
- SKID=1 state machine, with state encoded as {`skid_v`, `main_v`}:
  - EMPTY (00). On input transfer: load main, go to BUSY. Otherwise stay.
  - BUSY (01), with four cases:
    - Input and output transfer: load main, stay BUSY.
    - Output transfer only: clear main, go to EMPTY.
    - Input transfer only: load skid, go to FULL.
    - Neither: hold.
  - FULL (11). `in_ready`=0. On output transfer: main ← skid, clear skid, go to BUSY. Otherwise hold.
  - `in_ready` = !`skid_v`. It is a register-derived signal with no combinational path from `out_ready`.
- SKID=0 behaviour:
  - `in_ready` = !`main_v` | `out_ready`.
  - States are EMPTY and BUSY only, with the same transfers as above.
- Bubble zeroing: any entry that is cleared also has its data field set to 0, so an invalid slot reads as a nop.
- Flush has priority over everything except reset:
  - Next state is EMPTY; both valids and both data registers become 0.
  - An input transfer in the flush cycle is consumed (upstream sees the handshake) but discarded.
  - `stall_cnt` is not affected by flush.
- `stall_cnt` increments by 1 in any cycle with `in_valid`=1 and `in_ready`=0. It holds at 2^CNT_W−1 and is cleared only by reset.
- Payload bits are passed unmodified; the block never interprets them.

## Timing
- Reset values, one cycle after `reset` is sampled high:
  - `out_valid`=0, `out_data`=0, `stall_cnt`=0, `in_ready`=1.
  - Internal `skid_v`=0, `main_v`=0.
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N. This is one cycle.
- Throughput: 1 payload per cycle while `out_ready`=1, for both SKID settings.
- SKID=1:
  - `in_ready` falls one cycle after the first refused output transfer that coincides with an input transfer.
  - It rises one cycle after the output transfer that drains skid.
  - No payload is lost or duplicated under any `out_ready` pattern.
- Ordering is strictly FIFO. Skid contents are always younger than main contents.
- A reset or flush asserted mid-operation (BUSY or FULL) empties the buffer at the next edge.
- Simultaneous `reset` and `flush`: reset wins, and `stall_cnt` is cleared.

## Structure
- The shared package `pipe_pkg` holds:
  - the stage-payload typedefs (e.g. `mw_payload_t` packing instr[31:0], pc[31:0], write_reg[4:0], dm_out[31:0], result[31:0] = 133 bits);
  - the state encoding constants `ST_EMPTY`, `ST_BUSY`, `ST_FULL`.
- Natural sub-module: `sat_counter` (parameter CNT_W; ports `inc`, `clr`, `q`), used for `stall_cnt`.
- The skid path is generated only when SKID=1.

## Test plan
- Reset then streaming: W=133, SKID=1, `out_ready`=1, `in_data`=1,2,3 on consecutive cycles. Expect `out_data`=1,2,3 one cycle later with `out_valid`=1 throughout, and `stall_cnt`=0.
- Backpressure: send 0xA then 0xB while `out_ready`=0.
  - Expect FULL and `in_ready`=0 in the next cycle.
  - Hold `in_valid`=1 for 3 more cycles: expect `stall_cnt`=3.
  - Raise `out_ready`: expect out 0xA, then 0xB, and `in_ready` returns to 1.
- Flush in FULL: while holding 0xA/0xB, pulse `flush` with `in_valid`=1 and `in_data`=0xC. Next cycle expect `out_valid`=0, `out_data`=0, EMPTY, and 0xC never appears.
- Bubble zeroing: a single payload 0x5 is drained with no refill. Expect `out_data`=0 with `out_valid`=0 the following cycle.
- SKID=0 pass-through: `out_ready`=0 with `main_v`=1 gives `in_ready`=0 in the same cycle. `out_ready`=1 gives `in_ready`=1 in the same cycle, and the new payload replaces the old one at the next edge.
- Counter saturation: CNT_W=2, 6 stalled cycles. Expect `stall_cnt` to saturate at 3 and remain 3 through a flush.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: stage payload
// layouts and the buffer occupancy encoding {skid_v, main_v}.
package pipe_pkg;

  // MEM/WB stage payload, concatenated by the top level into in_data.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  write_reg;
    logic [31:0] dm_out;
    logic [31:0] result;
  } mw_payload_t;

  localparam int MW_W = $bits(mw_payload_t);

  // Occupancy state; bit 1 is the skid valid, bit 0 the main valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  assign q = r_q;

  // Count up on inc, stop at the maximum value, clear has priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: opaque payload with valid/ready handshake,
// optional 2-entry skid buffer (registered in_ready), flush-to-bubble and a
// saturating stall-cycle counter. Cleared slots always read back as zero.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int W     = 133,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic         w_main_v;
  logic [W-1:0] w_main_d;
  logic         w_in_ready;
  logic         w_stall;

  assign in_ready  = w_in_ready;
  assign out_valid = w_main_v;
  assign out_data  = w_main_d;

  // A stall is upstream offering while we refuse; flush does not matter here.
  assign w_stall = in_valid & ~w_in_ready;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(reset),
    .inc(w_stall),
    .q  (stall_cnt)
  );

  generate
    if (SKID == 1) begin : g_skid
      state_t       r_state, w_state_next;
      logic [W-1:0] r_main_d, w_main_d_next;
      logic [W-1:0] r_skid_d, w_skid_d_next;
      logic         w_in_fire, w_out_fire;

      // in_ready depends only on the skid register, never on out_ready.
      assign w_in_ready = (r_state != ST_FULL);
      assign w_main_v   = (r_state != ST_EMPTY);
      assign w_main_d   = r_main_d;
      assign w_in_fire  = in_valid & w_in_ready;
      assign w_out_fire = w_main_v & out_ready;

      // Next occupancy and data; flush drops everything including this input.
      always_comb begin
        w_state_next  = r_state;
        w_main_d_next = r_main_d;
        w_skid_d_next = r_skid_d;
        if (flush) begin
          w_state_next  = ST_EMPTY;
          w_main_d_next = '0;
          w_skid_d_next = '0;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_in_fire) begin
                w_state_next  = ST_BUSY;
                w_main_d_next = in_data;
              end
            end
            ST_BUSY: begin
              if (w_in_fire && w_out_fire) begin
                w_main_d_next = in_data;
              end else if (w_out_fire) begin
                w_state_next  = ST_EMPTY;
                w_main_d_next = '0;
              end else if (w_in_fire) begin
                w_state_next  = ST_FULL;
                w_skid_d_next = in_data;
              end
            end
            ST_FULL: begin
              if (w_out_fire) begin
                w_state_next  = ST_BUSY;
                w_main_d_next = r_skid_d;
                w_skid_d_next = '0;
              end
            end
            default: begin
              w_state_next  = ST_EMPTY;
              w_main_d_next = '0;
              w_skid_d_next = '0;
            end
          endcase
        end
      end

      // State and data registers with synchronous reset to an empty bubble.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state  <= ST_EMPTY;
          r_main_d <= '0;
          r_skid_d <= '0;
        end else begin
          r_state  <= w_state_next;
          r_main_d <= w_main_d_next;
          r_skid_d <= w_skid_d_next;
        end
      end
    end else begin : g_noskid
      state_t       r_state, w_state_next;
      logic [W-1:0] r_main_d, w_main_d_next;
      logic         w_in_fire, w_out_fire;

      // Single register: accept whenever the slot is free or being drained.
      assign w_main_v   = (r_state == ST_BUSY);
      assign w_main_d   = r_main_d;
      assign w_in_ready = ~w_main_v | out_ready;
      assign w_in_fire  = in_valid & w_in_ready;
      assign w_out_fire = w_main_v & out_ready;

      // Load on input, otherwise clear to a bubble on output; flush wins.
      always_comb begin
        w_state_next  = r_state;
        w_main_d_next = r_main_d;
        if (flush) begin
          w_state_next  = ST_EMPTY;
          w_main_d_next = '0;
        end else if (w_in_fire) begin
          w_state_next  = ST_BUSY;
          w_main_d_next = in_data;
        end else if (w_out_fire) begin
          w_state_next  = ST_EMPTY;
          w_main_d_next = '0;
        end
      end

      // State and data registers with synchronous reset to an empty bubble.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state  <= ST_EMPTY;
          r_main_d <= '0;
        end else begin
          r_state  <= w_state_next;
          r_main_d <= w_main_d_next;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: dut_a is the default skid build, dut_b a pass-through
// build with a 2-bit stall counter for the saturation case.
module tb_pipe_stage_buf;

  localparam int WA = 133;
  localparam int WB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [WA-1:0] a_in_data, a_out_data;
  logic [15:0]   a_stall_cnt;

  logic          b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [WB-1:0] b_in_data, b_out_data;
  logic [1:0]    b_stall_cnt;

  pipe_stage_buf #(.W(WA), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(a_reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage_buf #(.W(WB), .SKID(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt)
  );

  int n_tests  = 0;
  int n_failed = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Advance one active edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;

    // Reset state
    check("a_rst_out_valid", 256'(a_out_valid), 256'(0));
    check("a_rst_out_data",  256'(a_out_data),  256'(0));
    check("a_rst_stall",     256'(a_stall_cnt), 256'(0));
    check("a_rst_in_ready",  256'(a_in_ready),  256'(1));

    // Streaming 1,2,3 with out_ready=1
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    a_in_data = 133'd1; tick();
    check("a_stream1_valid", 256'(a_out_valid), 256'(1));
    check("a_stream1_data",  256'(a_out_data),  256'(1));
    a_in_data = 133'd2; tick();
    check("a_stream2_data",  256'(a_out_data),  256'(2));
    a_in_data = 133'd3; tick();
    check("a_stream3_data",  256'(a_out_data),  256'(3));
    check("a_stream3_valid", 256'(a_out_valid), 256'(1));
    // Drain with no refill: bubble must be zeroed
    a_in_valid = 1'b0; a_in_data = 133'd5; tick();
    check("a_bubble_valid",  256'(a_out_valid), 256'(0));
    check("a_bubble_data",   256'(a_out_data),  256'(0));
    check("a_stream_stall",  256'(a_stall_cnt), 256'(0));

    // Backpressure: 0xA then 0xB with out_ready=0
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 133'hA; tick();
    check("a_bp_busy_in_ready", 256'(a_in_ready), 256'(1));
    a_in_data = 133'hB; tick();
    check("a_bp_full_in_ready", 256'(a_in_ready), 256'(0));
    check("a_bp_full_data",     256'(a_out_data), 256'(133'hA));
    a_in_data = 133'hD;
    for (int i = 0; i < 3; i++) tick();
    check("a_bp_stall3",        256'(a_stall_cnt), 256'(3));
    check("a_bp_hold_data",     256'(a_out_data),  256'(133'hA));
    a_in_valid = 1'b0; a_out_ready = 1'b1; tick();
    check("a_bp_drain1_data",   256'(a_out_data),  256'(133'hB));
    check("a_bp_drain1_ready",  256'(a_in_ready),  256'(1));
    tick();
    check("a_bp_drain2_valid",  256'(a_out_valid), 256'(0));
    check("a_bp_drain2_data",   256'(a_out_data),  256'(0));

    // Flush in FULL with 0xC offered
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 133'hA; tick();
    a_in_data = 133'hB; tick();
    check("a_fl_full_in_ready", 256'(a_in_ready), 256'(0));
    a_flush = 1'b1; a_in_data = 133'hC; tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("a_fl_valid",    256'(a_out_valid), 256'(0));
    check("a_fl_data",     256'(a_out_data),  256'(0));
    check("a_fl_in_ready", 256'(a_in_ready),  256'(1));
    check("a_fl_stall",    256'(a_stall_cnt), 256'(4));
    a_out_ready = 1'b1; tick();
    check("a_fl_no_c_valid", 256'(a_out_valid), 256'(0));

    // Flush in BUSY consumes and discards the incoming payload
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 133'hE; tick();
    a_flush = 1'b1; a_in_data = 133'hF;
    #1 check("a_flb_in_ready", 256'(a_in_ready), 256'(1));
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    check("a_flb_valid", 256'(a_out_valid), 256'(0));
    check("a_flb_data",  256'(a_out_data),  256'(0));

    // Reset together with flush while BUSY clears counter and buffer
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 133'h7; tick();
    a_reset = 1'b1; a_flush = 1'b1; tick();
    a_reset = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
    check("a_rf_valid", 256'(a_out_valid), 256'(0));
    check("a_rf_stall", 256'(a_stall_cnt), 256'(0));

    // SKID=0: combinational in_ready and replace-on-transfer
    check("b_rst_in_ready", 256'(b_in_ready), 256'(1));
    b_in_valid = 1'b1; b_in_data = 8'h11; tick();
    check("b_hold_in_ready", 256'(b_in_ready), 256'(0));
    check("b_hold_data",     256'(b_out_data), 256'(8'h11));
    b_out_ready = 1'b1;
    #1 check("b_pass_in_ready", 256'(b_in_ready), 256'(1));
    b_in_data = 8'h22; tick();
    check("b_pass_data",  256'(b_out_data),  256'(8'h22));
    check("b_pass_stall", 256'(b_stall_cnt), 256'(0));

    // Counter saturation on a 2-bit counter: 6 stalled cycles
    b_out_ready = 1'b0; b_in_data = 8'h33;
    tick(); tick();
    check("b_stall2", 256'(b_stall_cnt), 256'(2));
    for (int i = 0; i < 4; i++) tick();
    check("b_stall_sat",  256'(b_stall_cnt), 256'(3));
    check("b_sat_data",   256'(b_out_data),  256'(8'h22));
    b_flush = 1'b1; tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    check("b_fl_stall", 256'(b_stall_cnt), 256'(3));
    check("b_fl_valid", 256'(b_out_valid), 256'(0));
    check("b_fl_data",  256'(b_out_data),  256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
